// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the microcode sequencer: microcode words, sequencer states,
// wait-source indices and the opcode map used by the microprogram ROM.
package microcode_sequencer_pkg;

    typedef enum logic [4:0] {
        ENDMICRO,
        PC_to_MAR,
        RAM_to_IR,
        INC_PC,
        PC_to_MAR_ADDR,
        RAM_to_MAR,
        RAM_to_A,
        RAM_to_B,
        A_to_RAM,
        ALU_ADD,
        RAM_to_PC,
        RAM_to_PC_CF,
        RAM_to_PC_ZF,
        START_MT,
        START_UT,
        START_FT,
        START_DD,
        START_GPU,
        WAIT_MT,
        WAIT_UT,
        WAIT_FT,
        WAIT_DD,
        WAIT_GPU,
        HLT_CLK
    } Microcode_enum;

    typedef enum logic [2:0] {
        F0,
        F1,
        F2,
        EXEC,
        HALT
    } Seq_state_enum;

    localparam int FETCH_LEN = 3;

    localparam int WAIT_IDX_MT  = 0;
    localparam int WAIT_IDX_UT  = 1;
    localparam int WAIT_IDX_FT  = 2;
    localparam int WAIT_IDX_DD  = 3;
    localparam int WAIT_IDX_GPU = 4;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_LOAD    = 8'h01;
    localparam logic [7:0] OP_WAIT_MT = 8'h02;
    localparam logic [7:0] OP_HALT    = 8'h03;
    localparam logic [7:0] OP_LONG    = 8'h04;
    localparam logic [7:0] OP_GPU     = 8'h05;
    localparam logic [7:0] OP_JC      = 8'h06;

    // Source index of a WAIT_* word, -1 for every other word.
    function automatic int wait_index(input Microcode_enum w);
        case (w)
            WAIT_MT:  return WAIT_IDX_MT;
            WAIT_UT:  return WAIT_IDX_UT;
            WAIT_FT:  return WAIT_IDX_FT;
            WAIT_DD:  return WAIT_IDX_DD;
            WAIT_GPU: return WAIT_IDX_GPU;
            default:  return -1;
        endcase
    endfunction

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Combinational microprogram store indexed by {opcode, step}.
// Anything not listed, including unknown opcodes, reads as ENDMICRO.
module microcode_rom
    import microcode_sequencer_pkg::*;
#(
    parameter int OPCODE_W     = 8,
    parameter int STEPS_PER_OP = 8,
    localparam int STEP_W      = $clog2(STEPS_PER_OP)
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [STEP_W-1:0]   step_i,
    output Microcode_enum       word_o
);

    // Steps are compared at full width so entries beyond STEPS_PER_OP never alias.
    logic [31:0] step_ext;
    assign step_ext = 32'(step_i);

    always_comb begin
        word_o = ENDMICRO;
        case (opcode_i)
            OPCODE_W'(OP_LOAD): begin
                case (step_ext)
                    32'd0:   word_o = PC_to_MAR_ADDR;
                    32'd1:   word_o = RAM_to_MAR;
                    32'd2:   word_o = RAM_to_A;
                    default: word_o = ENDMICRO;
                endcase
            end
            OPCODE_W'(OP_WAIT_MT): begin
                case (step_ext)
                    32'd0:   word_o = START_MT;
                    32'd1:   word_o = WAIT_MT;
                    default: word_o = ENDMICRO;
                endcase
            end
            OPCODE_W'(OP_HALT): begin
                case (step_ext)
                    32'd0:   word_o = RAM_to_MAR;
                    32'd1:   word_o = HLT_CLK;
                    32'd2:   word_o = RAM_to_A;
                    default: word_o = ENDMICRO;
                endcase
            end
            OPCODE_W'(OP_LONG): begin
                case (step_ext)
                    32'd0:   word_o = RAM_to_MAR;
                    32'd1:   word_o = RAM_to_A;
                    32'd2:   word_o = RAM_to_B;
                    32'd3:   word_o = ALU_ADD;
                    default: word_o = ENDMICRO;
                endcase
            end
            OPCODE_W'(OP_GPU): begin
                case (step_ext)
                    32'd0:   word_o = START_GPU;
                    32'd1:   word_o = WAIT_GPU;
                    default: word_o = ENDMICRO;
                endcase
            end
            OPCODE_W'(OP_JC): begin
                case (step_ext)
                    32'd0:   word_o = PC_to_MAR_ADDR;
                    32'd1:   word_o = RAM_to_PC_CF;
                    default: word_o = ENDMICRO;
                endcase
            end
            default: word_o = ENDMICRO;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Registered microcode sequencer: fixed fetch prologue, per-opcode microprogram,
// WAIT_* stalls on unit busy, HALT with resume, external stall and overrun flag.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int OPCODE_W     = 8,
    parameter int STEPS_PER_OP = 8,
    parameter int NUM_WAIT_SRC = 5,
    localparam int STEP_W      = $clog2(STEPS_PER_OP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    resume_i,
    input  logic [OPCODE_W-1:0]     ir_opcode,
    input  logic [NUM_WAIT_SRC-1:0] wait_busy,
    output Microcode_enum           current_microcode,
    output logic [STEP_W-1:0]       ucode_step,
    output logic                    fetching,
    output logic                    halted,
    output logic                    ucode_overrun
);

    Seq_state_enum     state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    Microcode_enum     mc_q, mc_d;
    Microcode_enum     rom_word;
    logic              over_q, over_d;
    logic              advance;
    logic              last_step;
    logic              busy_sel;
    int                widx;

    assign last_step = (step_q == STEP_W'(STEPS_PER_OP - 1));

    // The ROM is addressed with the next step so the output word can be registered.
    microcode_rom #(
        .OPCODE_W    (OPCODE_W),
        .STEPS_PER_OP(STEPS_PER_OP)
    ) u_rom (
        .opcode_i(ir_opcode),
        .step_i  (step_d),
        .word_o  (rom_word)
    );

    always_comb begin
        widx     = wait_index(mc_q);
        busy_sel = 1'b0;
        for (int i = 0; i < NUM_WAIT_SRC; i++) begin
            if (i == widx) busy_sel = wait_busy[i];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        over_d  = over_q;
        advance = 1'b0;
        case (state_q)
            F0: state_d = F1;
            F1: state_d = F2;
            F2: begin
                state_d = EXEC;
                step_d  = '0;
            end
            EXEC: begin
                if (mc_q == ENDMICRO) begin
                    state_d = F0;
                    step_d  = '0;
                end else if (widx >= 0) begin
                    advance = !busy_sel;
                end else if (mc_q == HLT_CLK) begin
                    state_d = HALT;
                end else begin
                    advance = 1'b1;
                end
            end
            HALT:    advance = resume_i;
            default: state_d = F0;
        endcase
        // Running off the end of a microprogram without ENDMICRO refetches and flags it.
        if (advance) begin
            if (last_step) begin
                state_d = F0;
                step_d  = '0;
                over_d  = 1'b1;
            end else begin
                state_d = EXEC;
                step_d  = step_q + STEP_W'(1);
            end
        end
    end

    always_comb begin
        case (state_d)
            F0:      mc_d = PC_to_MAR;
            F1:      mc_d = RAM_to_IR;
            F2:      mc_d = INC_PC;
            EXEC:    mc_d = rom_word;
            HALT:    mc_d = HLT_CLK;
            default: mc_d = PC_to_MAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F0;
            step_q  <= '0;
            mc_q    <= PC_to_MAR;
            over_q  <= 1'b0;
        end else if (!stall_i) begin
            state_q <= state_d;
            step_q  <= step_d;
            mc_q    <= mc_d;
            over_q  <= over_d;
        end
    end

    assign current_microcode = mc_q;
    assign ucode_step        = (state_q == EXEC) ? step_q : '0;
    assign fetching          = (state_q == F0) || (state_q == F1) || (state_q == F2);
    assign halted            = (state_q == HALT);
    assign ucode_overrun     = over_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: fetch, execute, waits, halt/resume,
// stall, reset override and overrun on a 4-step instance.
module tb_microcode_sequencer;
    import microcode_sequencer_pkg::*;

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic          resume_i;
    logic [7:0]    ir_opcode;
    logic [4:0]    wait_busy;

    Microcode_enum current_microcode;
    logic [2:0]    ucode_step;
    logic          fetching;
    logic          halted;
    logic          ucode_overrun;

    Microcode_enum mc4;
    logic [1:0]    step4;
    logic          fetching4;
    logic          halted4;
    logic          overrun4;

    int errors = 0;
    int checks = 0;

    microcode_sequencer #(
        .OPCODE_W    (8),
        .STEPS_PER_OP(8),
        .NUM_WAIT_SRC(5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .resume_i         (resume_i),
        .ir_opcode        (ir_opcode),
        .wait_busy        (wait_busy),
        .current_microcode(current_microcode),
        .ucode_step       (ucode_step),
        .fetching         (fetching),
        .halted           (halted),
        .ucode_overrun    (ucode_overrun)
    );

    microcode_sequencer #(
        .OPCODE_W    (8),
        .STEPS_PER_OP(4),
        .NUM_WAIT_SRC(5)
    ) dut4 (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .resume_i         (resume_i),
        .ir_opcode        (ir_opcode),
        .wait_busy        (wait_busy),
        .current_microcode(mc4),
        .ucode_step       (step4),
        .fetching         (fetching4),
        .halted           (halted4),
        .ucode_overrun    (overrun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input Microcode_enum mc, input int stp,
                        input logic f, input logic h);
        chk({tag, "/mc"},    32'(current_microcode), 32'(mc));
        chk({tag, "/step"},  32'(ucode_step),        32'(stp));
        chk({tag, "/fetch"}, 32'(fetching),          32'(f));
        chk({tag, "/halt"},  32'(halted),            32'(h));
    endtask

    task automatic ex(input string tag, input Microcode_enum mc, input int stp,
                      input logic f, input logic h);
        look(tag, mc, stp, f, h);
        tick();
    endtask

    Microcode_enum long_seq [4] = '{RAM_to_MAR, RAM_to_A, RAM_to_B, ALU_ADD};

    initial begin
        rst       = 1'b1;
        stall_i   = 1'b0;
        resume_i  = 1'b0;
        ir_opcode = OP_NOP;
        wait_busy = 5'b0;
        tick();
        tick();

        // Reset state
        look("rst", PC_to_MAR, 0, 1'b1, 1'b0);
        chk("rst/overrun", 32'(ucode_overrun), 32'd0);
        rst = 1'b0;

        // 1: NOP opcode
        ex("nop_f0", PC_to_MAR, 0, 1'b1, 1'b0);
        ex("nop_f1", RAM_to_IR, 0, 1'b1, 1'b0);
        ex("nop_f2", INC_PC,    0, 1'b1, 1'b0);
        ex("nop_e0", ENDMICRO,  0, 1'b0, 1'b0);

        // 2: LOAD opcode
        ir_opcode = OP_LOAD;
        ex("ld_f0", PC_to_MAR,      0, 1'b1, 1'b0);
        ex("ld_f1", RAM_to_IR,      0, 1'b1, 1'b0);
        ex("ld_f2", INC_PC,         0, 1'b1, 1'b0);
        ex("ld_e0", PC_to_MAR_ADDR, 0, 1'b0, 1'b0);
        ex("ld_e1", RAM_to_MAR,     1, 1'b0, 1'b0);
        ex("ld_e2", RAM_to_A,       2, 1'b0, 1'b0);
        ex("ld_e3", ENDMICRO,       3, 1'b0, 1'b0);

        // 3: WAIT_MT with busy high for the first 5 wait cycles
        ir_opcode = OP_WAIT_MT;
        wait_busy = 5'b00001;
        ex("wmt_f0", PC_to_MAR, 0, 1'b1, 1'b0);
        ex("wmt_f1", RAM_to_IR, 0, 1'b1, 1'b0);
        ex("wmt_f2", INC_PC,    0, 1'b1, 1'b0);
        ex("wmt_e0", START_MT,  0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            look("wmt_hold", WAIT_MT, 1, 1'b0, 1'b0);
            if (i == 5) wait_busy = 5'b00000;
            tick();
        end
        ex("wmt_end", ENDMICRO, 2, 1'b0, 1'b0);

        // 3b: busy already low, WAIT_MT lasts one cycle
        ex("wmt0_f0", PC_to_MAR, 0, 1'b1, 1'b0);
        ex("wmt0_f1", RAM_to_IR, 0, 1'b1, 1'b0);
        ex("wmt0_f2", INC_PC,    0, 1'b1, 1'b0);
        ex("wmt0_e0", START_MT,  0, 1'b0, 1'b0);
        ex("wmt0_e1", WAIT_MT,   1, 1'b0, 1'b0);
        ex("wmt0_e2", ENDMICRO,  2, 1'b0, 1'b0);

        // 4: HLT_CLK at step 1, resume after 10 halted cycles
        ir_opcode = OP_HALT;
        ex("hlt_f0", PC_to_MAR,  0, 1'b1, 1'b0);
        ex("hlt_f1", RAM_to_IR,  0, 1'b1, 1'b0);
        ex("hlt_f2", INC_PC,     0, 1'b1, 1'b0);
        ex("hlt_e0", RAM_to_MAR, 0, 1'b0, 1'b0);
        ex("hlt_e1", HLT_CLK,    1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            look("hlt_hold", HLT_CLK, 0, 1'b0, 1'b1);
            if (i == 3) begin
                stall_i  = 1'b1;
                resume_i = 1'b1;
            end
            if (i == 9) resume_i = 1'b1;
            tick();
            stall_i  = 1'b0;
            resume_i = 1'b0;
        end
        ex("hlt_res", RAM_to_A, 2, 1'b0, 1'b0);
        ex("hlt_end", ENDMICRO, 3, 1'b0, 1'b0);

        // 5: stall during LOAD step 2
        ir_opcode = OP_LOAD;
        ex("stl_f0", PC_to_MAR,      0, 1'b1, 1'b0);
        ex("stl_f1", RAM_to_IR,      0, 1'b1, 1'b0);
        ex("stl_f2", INC_PC,         0, 1'b1, 1'b0);
        ex("stl_e0", PC_to_MAR_ADDR, 0, 1'b0, 1'b0);
        ex("stl_e1", RAM_to_MAR,     1, 1'b0, 1'b0);
        look("stl_e2", RAM_to_A, 2, 1'b0, 1'b0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            look("stl_frz", RAM_to_A, 2, 1'b0, 1'b0);
        end
        stall_i = 1'b0;
        tick();
        ex("stl_e3", ENDMICRO, 3, 1'b0, 1'b0);

        // 5b: reset (with stall asserted) during WAIT_GPU
        ir_opcode = OP_GPU;
        wait_busy = 5'b10000;
        ex("gpu_f0", PC_to_MAR, 0, 1'b1, 1'b0);
        ex("gpu_f1", RAM_to_IR, 0, 1'b1, 1'b0);
        ex("gpu_f2", INC_PC,    0, 1'b1, 1'b0);
        ex("gpu_e0", START_GPU, 0, 1'b0, 1'b0);
        ex("gpu_w0", WAIT_GPU,  1, 1'b0, 1'b0);
        look("gpu_w1", WAIT_GPU, 1, 1'b0, 1'b0);
        rst     = 1'b1;
        stall_i = 1'b1;
        tick();
        look("gpu_rst", PC_to_MAR, 0, 1'b1, 1'b0);
        chk("gpu_rst/overrun", 32'(ucode_overrun), 32'd0);
        rst       = 1'b0;
        stall_i   = 1'b0;
        wait_busy = 5'b0;

        // 6: overrun on the 4-step instance, clean ENDMICRO on the 8-step one
        ir_opcode = OP_LONG;
        ex("lng_f0", PC_to_MAR, 0, 1'b1, 1'b0);
        ex("lng_f1", RAM_to_IR, 0, 1'b1, 1'b0);
        ex("lng_f2", INC_PC,    0, 1'b1, 1'b0);
        chk("lng4/overrun_pre", 32'(overrun4), 32'd0);
        for (int s = 0; s < 4; s++) begin
            chk("lng4/mc",   32'(mc4),   32'(long_seq[s]));
            chk("lng4/step", 32'(step4), 32'(s));
            ex("lng_e", long_seq[s], s, 1'b0, 1'b0);
        end
        look("lng_e4", ENDMICRO, 4, 1'b0, 1'b0);
        chk("lng/overrun8",  32'(ucode_overrun), 32'd0);
        chk("lng4/mc_f0",    32'(mc4),           32'(PC_to_MAR));
        chk("lng4/step_f0",  32'(step4),         32'd0);
        chk("lng4/fetch_f0", 32'(fetching4),     32'd1);
        chk("lng4/overrun",  32'(overrun4),      32'd1);
        ir_opcode = OP_NOP;
        repeat (6) tick();
        chk("lng4/sticky",  32'(overrun4), 32'd1);
        chk("lng4/halted",  32'(halted4),  32'd0);
        rst = 1'b1;
        tick();
        chk("lng4/rst_clr", 32'(overrun4), 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
